bcd_serial_adder: RTL and testbench
===================================

BCD_SERIAL_ADDER -- requirements
Module: bcd_serial_adder

Interface
REQ-001 SHALL have parameter DIGITS, default 4, giving the number of packed BCD digits per operand; legal range 1..16.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset that is synchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1, operand presentation.
REQ-005 SHALL have port in_ready, output, 1, operand acceptance.
REQ-006 SHALL have ports a and b, input, 4*DIGITS, packed BCD operands, least significant digit in bits [3:0].
REQ-007 SHALL have port c_in, input, 1, decimal carry-in.
REQ-008 SHALL have port out_valid, output, 1, result presentation.
REQ-009 SHALL have port out_ready, input, 1, result acceptance.
REQ-010 SHALL have port sum, output, 4*DIGITS, packed BCD result.
REQ-011 SHALL have port c_out, output, 1, decimal carry-out of the most significant digit.
REQ-012 SHALL have port out_of_range, output, 1, high when any operand digit exceeds 9.

Function
REQ-013 SHALL implement FSM states IDLE, RUN and DONE.
REQ-014 SHALL drive in_ready high only in IDLE.
REQ-015 SHALL, on in_valid && in_ready, capture a, b and c_in, clear the digit index, and enter RUN.
REQ-016 SHALL, in RUN, process one digit per cycle, least significant digit first.
- Per-digit sum: t = a_i + b_i + carry.
- If t > 9, the digit result is (t + 6) mod 16 and the next carry is 1.
- Otherwise the digit result is t and the next carry is 0.
REQ-017 SHALL seed the carry with c_in for digit 0.
REQ-018 SHALL enter DONE at the edge that completes digit DIGITS-1, i.e. DIGITS cycles after the accepting edge.
- At that edge sum, c_out and out_of_range are registered.
REQ-019 SHALL drive out_valid high only in DONE.
- sum, c_out and out_of_range SHALL hold stable while out_valid && !out_ready.
REQ-020 SHALL return to IDLE on out_valid && out_ready.
- in_valid asserted in that same cycle is not accepted; there is one bubble cycle.
REQ-021 SHALL make out_of_range sticky across the digits of one operation and clear it on acceptance of new operands.
- sum and c_out SHALL still follow REQ-016 when out_of_range is set.
REQ-022 SHALL ignore changes on a, b and c_in while in RUN or DONE.
REQ-023 SHALL, for DIGITS=1, complete in one RUN cycle.

Reset
REQ-024 SHALL, on rst_n low at a rising clk edge, enter IDLE from any state, abandoning any operation in progress.
REQ-025 SHALL set reset values: in_ready 1 (after the reset edge), out_valid 0, sum 0, c_out 0, out_of_range 0, digit index 0, carry 0.

Configuration
REQ-026 SHALL, with macro BCD_SERIAL_ADDER_SUB_EN defined, add input port sub (1 bit), captured with the operands.
- sub=1 computes a - b by substituting (9 - b_i) for b_i and forcing the initial carry to 1, ignoring c_in.
- c_out=1 means a >= b; c_out=0 means a negative result, given in ten's complement.
REQ-027 SHALL, without BCD_SERIAL_ADDER_SUB_EN, omit the sub port and perform addition only.

Structure
REQ-028 SHALL take the following from shared package bcd_pkg:
- bcd_digit_t (4-bit typedef)
- BCD_MAX = 9 and BCD_ADJ = 6
- the FSM state enum
REQ-029 SHALL instantiate one combinational sub-module, bcd_digit_add (digit, digit, carry -> digit, carry), for the per-digit step.

Verification
REQ-030 SHALL cover, with DIGITS=4: a=0x1234, b=0x5678, c_in=0 -> sum=0x6912, c_out=0, out_of_range=0, out_valid 4 cycles after acceptance.
REQ-031 SHALL cover: a=0x9999, b=0x9999, c_in=1 -> sum=0x9999, c_out=1.
REQ-032 SHALL cover: a=0x00A1, b=0x0001 -> out_of_range=1; the following operation, a=0x0001, b=0x0001, gives out_of_range=0 and sum=0x0002.
REQ-033 SHALL cover backpressure: out_ready held low 5 cycles -> sum stable, in_ready=0 throughout; in_valid high at the out_ready handshake is accepted one cycle later.
REQ-034 SHALL cover reset mid-operation: rst_n low at RUN digit 2 -> IDLE and all outputs at reset values next cycle; no out_valid for the aborted operation.
REQ-035 SHALL cover, with BCD_SERIAL_ADDER_SUB_EN: a=0x0100, b=0x0001, sub=1 -> sum=0x0099, c_out=1; a=0x0001, b=0x0002, sub=1 -> sum=0x9999, c_out=0.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared BCD types and constants: digit typedef, decimal limits and the
// serial adder FSM state encoding.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_ADJ = 4'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_digit_add.sv
// One decimal digit step: a + b + carry with the +6 correction when the
// binary sum passes nine.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       c_in,
  output bcd_digit_t sum,
  output logic       c_out
);

  logic [4:0] t;

  always_comb begin
    t     = {1'b0, a} + {1'b0, b} + {4'b0000, c_in};
    c_out = t > {1'b0, BCD_MAX};
    // Adding the correction in four bits gives (t + 6) mod 16 directly.
    sum   = c_out ? (t[3:0] + BCD_ADJ) : t[3:0];
  end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder, one digit per cycle, LSD first.
// Optional subtract mode (ten's complement) with BCD_SERIAL_ADDER_SUB_EN.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; the source holds its payload until then, and ready never
// depends combinationally on valid.
module bcd_serial_adder
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                c_in,
`ifdef BCD_SERIAL_ADDER_SUB_EN
  input  logic                sub,
`endif
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] sum,
  output logic                c_out,
  output logic                out_of_range,
  output state_t              dbg_state
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  state_t        state;
  logic [W-1:0]  a_sh;
  logic [W-1:0]  b_sh;
  logic [W-1:0]  s_sh;
  logic [W-1:0]  s_next;
  logic          carry;
  logic          oor_acc;
  logic [IW-1:0] idx;

  bcd_digit_t    a_dig;
  bcd_digit_t    b_dig;
  bcd_digit_t    b_eff;
  bcd_digit_t    d_sum;
  logic          d_co;
  logic          oor_dig;

`ifdef BCD_SERIAL_ADDER_SUB_EN
  logic sub_r;
  assign b_eff = sub_r ? (BCD_MAX - b_dig) : b_dig;
`else
  assign b_eff = b_dig;
`endif

  assign a_dig     = a_sh[3:0];
  assign b_dig     = b_sh[3:0];
  assign oor_dig   = (a_dig > BCD_MAX) || (b_dig > BCD_MAX);
  assign dbg_state = state;

  bcd_digit_add u_digit (
    .a     (a_dig),
    .b     (b_eff),
    .c_in  (carry),
    .sum   (d_sum),
    .c_out (d_co)
  );

  // Result digits enter at the top and drift down, so after the last digit
  // digit 0 sits in bits [3:0].
  if (DIGITS == 1) begin : g_one
    assign s_next = d_sum;
  end else begin : g_many
    assign s_next = {d_sum, s_sh[W-1:4]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      sum          <= '0;
      c_out        <= 1'b0;
      out_of_range <= 1'b0;
      idx          <= '0;
      carry        <= 1'b0;
      oor_acc      <= 1'b0;
      a_sh         <= '0;
      b_sh         <= '0;
      s_sh         <= '0;
`ifdef BCD_SERIAL_ADDER_SUB_EN
      sub_r        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_sh         <= a;
            b_sh         <= b;
            idx          <= '0;
            oor_acc      <= 1'b0;
            out_of_range <= 1'b0;
            in_ready     <= 1'b0;
            state        <= RUN;
`ifdef BCD_SERIAL_ADDER_SUB_EN
            sub_r        <= sub;
            carry        <= sub ? 1'b1 : c_in;
`else
            carry        <= c_in;
`endif
          end
        end
        RUN: begin
          a_sh    <= a_sh >> 4;
          b_sh    <= b_sh >> 4;
          s_sh    <= s_next;
          carry   <= d_co;
          oor_acc <= oor_acc | oor_dig;
          idx     <= idx + IW'(1);
          if (idx == LAST) begin
            state        <= DONE;
            out_valid    <= 1'b1;
            sum          <= s_next;
            c_out        <= d_co;
            out_of_range <= oor_acc | oor_dig;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Self-checking bench for bcd_serial_adder: decimal-arithmetic reference model,
// expected queue, directed corner cases and randomized operations.
`timescale 1ns/1ps
module tb_bcd_serial_adder;
  import bcd_pkg::*;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         c_out;
  logic         out_of_range;
  state_t       dbg_state;

  logic [W+1:0] exp_q[$];
  int           vectors;
  int           miscompares;

  bcd_serial_adder #(.DIGITS(DIGITS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .a            (a),
    .b            (b),
    .c_in         (c_in),
`ifdef BCD_SERIAL_ADDER_SUB_EN
    .sub          (sub),
`endif
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .sum          (sum),
    .c_out        (c_out),
    .out_of_range (out_of_range),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model: returns {out_of_range, c_out, sum} ----------------
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mc, input logic ms);
    logic         oor;
    logic         cy;
    logic [W-1:0] s;
    longint       va, vb, p, tot;
    int           da, db, t;
    oor = 1'b0; va = 0; vb = 0; p = 1; s = '0;
    for (int i = 0; i < DIGITS; i++) begin
      da = int'(ma[4*i +: 4]);
      db = int'(mb[4*i +: 4]);
      if (da > 9 || db > 9) oor = 1'b1;
      va += da * p;
      vb += db * p;
      p  *= 10;
    end
    if (!oor) begin
      tot = ms ? (va - vb + p) : (va + vb + longint'(mc));
      cy  = (tot >= p);
      tot = tot % p;
      for (int i = 0; i < DIGITS; i++) begin
        s[4*i +: 4] = 4'(tot % 10);
        tot = tot / 10;
      end
    end else begin
      // Non-decimal digits: apply the digit rule literally.
      cy = ms ? 1'b1 : mc;
      for (int i = 0; i < DIGITS; i++) begin
        da = int'(ma[4*i +: 4]);
        db = int'(mb[4*i +: 4]);
        if (ms) db = (9 - db) & 15;
        t = da + db + int'(cy);
        if (t > 9) begin
          s[4*i +: 4] = 4'((t + 6) & 15);
          cy = 1'b1;
        end else begin
          s[4*i +: 4] = 4'(t);
          cy = 1'b0;
        end
      end
    end
    return {oor, cy, s};
  endfunction

  // ---------------- comparison ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 64'(out_valid), 64'(0));
      end else begin
        chk("sum", 64'(sum), 64'(exp_q[0][W-1:0]));
        chk("c_out", 64'(c_out), 64'(exp_q[0][W]));
        chk("out_of_range", 64'(out_of_range), 64'(exp_q[0][W+1]));
        chk("busy_in_ready", 64'(in_ready), 64'(0));
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
  end

  // ---------------- drivers ----------------
  task automatic scramble();
    a    = W'($urandom);
    b    = W'($urandom);
    c_in = 1'($urandom);
    sub  = 1'($urandom);
  endtask

  task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                        input logic ts);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("launch_timeout", 64'(in_ready), 64'(1));
    a = ta; b = tb; c_in = tc; sub = ts; in_valid = 1'b1;
`ifdef BCD_SERIAL_ADDER_SUB_EN
    exp_q.push_back(model(ta, tb, tc, ts));
`else
    exp_q.push_back(model(ta, tb, tc, 1'b0));
`endif
    @(negedge clk);
    in_valid = 1'b0;
    scramble();
  endtask

  // Called right after launch: the current negedge is the first after the accept edge.
  task automatic collect(input int hold, input bit chain, input logic [W-1:0] ca,
                         input logic [W-1:0] cb);
    int n;
    n = 1;
    while (!out_valid && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 64'(n - 1), 64'(DIGITS));
    repeat (hold) begin
      chk("hold_in_ready", 64'(in_ready), 64'(0));
      @(negedge clk);
    end
    out_ready = 1'b1;
    if (chain) begin
      a = ca; b = cb; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
    end
    @(negedge clk);
    out_ready = 1'b0;
    if (chain) begin
      chk("bubble_not_accepted", 64'(in_ready), 64'(1));
      chk("bubble_state", 64'(dbg_state), 64'(IDLE));
      exp_q.push_back(model(ca, cb, 1'b0, 1'b0));
      @(negedge clk);
      chk("chain_accepted", 64'(in_ready), 64'(0));
      in_valid = 1'b0;
      scramble();
    end
  endtask

  function automatic logic [W-1:0] rand_bcd(input bit allow_bad);
    logic [W-1:0] v;
    for (int i = 0; i < DIGITS; i++) begin
      if (allow_bad && $urandom_range(0, 9) == 0) v[4*i +: 4] = 4'($urandom_range(10, 15));
      else v[4*i +: 4] = 4'($urandom_range(0, 9));
    end
    return v;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    vectors = 0; miscompares = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_sum", 64'(sum), 64'(0));
    chk("rst_c_out", 64'(c_out), 64'(0));
    chk("rst_oor", 64'(out_of_range), 64'(0));
    chk("rst_state", 64'(dbg_state), 64'(IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    // Hand-computed pins on the model itself.
    chk("pin_add", 64'(model(16'h1234, 16'h5678, 1'b0, 1'b0)), 64'({2'b00, 16'h6912}));
    chk("pin_max", 64'(model(16'h9999, 16'h9999, 1'b1, 1'b0)), 64'({2'b01, 16'h9999}));
    chk("pin_oor", 64'(model(16'h00A1, 16'h0001, 1'b0, 1'b0)), 64'({2'b10, 16'h0102}));
    chk("pin_sub_pos", 64'(model(16'h0100, 16'h0001, 1'b0, 1'b1)), 64'({2'b01, 16'h0099}));
    chk("pin_sub_neg", 64'(model(16'h0001, 16'h0002, 1'b0, 1'b1)), 64'({2'b00, 16'h9999}));

    launch(16'h1234, 16'h5678, 1'b0, 1'b0); collect(0, 1'b0, '0, '0);
    launch(16'h9999, 16'h9999, 1'b1, 1'b0); collect(0, 1'b0, '0, '0);
    launch(16'h00A1, 16'h0001, 1'b0, 1'b0); collect(1, 1'b0, '0, '0);
    launch(16'h0001, 16'h0001, 1'b0, 1'b0); collect(0, 1'b0, '0, '0);

    // Backpressure, then operands presented during the output handshake.
    launch(16'h4321, 16'h0789, 1'b1, 1'b0); collect(5, 1'b1, 16'h0505, 16'h0495);
    collect(0, 1'b0, '0, '0);

    // Reset while digit 2 is being processed.
    launch(16'h8765, 16'h4321, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("mid_rst_in_ready", 64'(in_ready), 64'(1));
    chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_sum", 64'(sum), 64'(0));
    chk("mid_rst_c_out", 64'(c_out), 64'(0));
    chk("mid_rst_oor", 64'(out_of_range), 64'(0));
    chk("mid_rst_state", 64'(dbg_state), 64'(IDLE));
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("aborted_no_out_valid", 64'(out_valid), 64'(0));
    end

`ifdef BCD_SERIAL_ADDER_SUB_EN
    launch(16'h0100, 16'h0001, 1'b0, 1'b1); collect(0, 1'b0, '0, '0);
    launch(16'h0001, 16'h0002, 1'b1, 1'b1); collect(0, 1'b0, '0, '0);
`endif

    for (int k = 0; k < 40; k++) begin
      logic ts;
`ifdef BCD_SERIAL_ADDER_SUB_EN
      ts = 1'($urandom);
`else
      ts = 1'b0;
`endif
      launch(rand_bcd(1'b1), rand_bcd(1'b1), 1'($urandom), ts);
      collect(int'($urandom_range(0, 3)), 1'b0, '0, '0);
    end

    @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
